// File: rtl/composer_pkg.sv
// Shared types and PS/2 scancode constants for the composer sequencing controller.
package composer_pkg;

  typedef enum logic [2:0] {
    MODE_MENU   = 3'd0,
    MODE_INSERT = 3'd1,
    MODE_DELETE = 3'd2,
    MODE_PLAY   = 3'd3,
    MODE_END    = 3'd4
  } mode_e;

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_INS_IDLE  = 3'd1,
    S_INS_BUSY  = 3'd2,
    S_DEL_STEP  = 3'd3,
    S_PLAY_NOTE = 3'd4,
    S_PLAY_END  = 3'd5,
    S_END       = 3'd6
  } state_e;

  localparam logic [7:0] KEY_INSERT = 8'h16;
  localparam logic [7:0] KEY_DELETE = 8'h1E;
  localparam logic [7:0] KEY_PLAY   = 8'h26;
  localparam logic [7:0] KEY_ESC    = 8'h76;
  localparam logic [7:0] KEY_BREAK  = 8'hF0;
  localparam logic [7:0] KEY_EXT    = 8'hE0;

endpackage

// File: rtl/ps2_make_filter.sv
// Passes only PS/2 make codes: swallows the byte following 0xF0 and ignores 0xE0 prefixes.
module ps2_make_filter
  import composer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       make_valid,
  output logic [7:0] make_code
);

  logic break_q;
  logic break_d;

  always_comb begin
    break_d    = break_q;
    make_valid = 1'b0;
    // Extended prefix leaves the pending-break flag untouched.
    if (key_valid && key_code != KEY_EXT) begin
      if (key_code == KEY_BREAK) begin
        break_d = 1'b1;
      end else if (break_q) begin
        break_d = 1'b0;
      end else begin
        make_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      break_q <= 1'b0;
    end else begin
      break_q <= break_d;
    end
  end

  assign make_code = key_code;

endmodule

// File: rtl/composer_ctrl.sv
// Composer sequencer: key-driven mode FSM, song pointer/count and record/erase/play timing.
// Define COMPOSER_LOOP_PLAY_EN to make playback wrap to the first note until Esc.
//
// state       | meaning
// S_MENU      | main menu, waiting for a command key
// S_INS_IDLE  | insert screen, next make code is recorded
// S_INS_BUSY  | hold-off after a record, keys dropped
// S_DEL_STEP  | one-cycle delete of the last note, then menu
// S_PLAY_NOTE | sounding note_addr for NOTE_TICKS cycles
// S_PLAY_END  | song_done cycle before returning to menu
// S_END       | absorbing; only reset leaves
module composer_ctrl
  import composer_pkg::*;
#(
  parameter int MAX_NOTES    = 32,
  parameter int ADDR_W       = 5,
  parameter int INSERT_TICKS = 5000000,
  parameter int NOTE_TICKS   = 25000000,
  parameter int TICK_W       = 25
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  output logic [2:0]        mode,
  output logic              record_en,
  output logic              erase_en,
  output logic              play_en,
  output logic [7:0]        note_code,
  output logic [ADDR_W-1:0] note_addr,
  output logic [ADDR_W:0]   note_count,
  output logic              busy,
  output logic              song_done
);

  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W+1)'(MAX_NOTES);
  localparam logic [TICK_W-1:0] INS_LAST  = TICK_W'(INSERT_TICKS - 1);
  localparam logic [TICK_W-1:0] NOTE_LAST = TICK_W'(NOTE_TICKS - 1);

  logic       make_valid;
  logic [7:0] make_code;

  ps2_make_filter u_filter (
    .clock      (clock),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .make_valid (make_valid),
    .make_code  (make_code)
  );

  state_e            state_q, state_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] note_addr_q, note_addr_d;
  logic [ADDR_W:0]   note_count_q, note_count_d;
  logic [7:0]        note_code_q, note_code_d;
  logic              record_en_q, record_en_d;
  logic              erase_en_q, erase_en_d;
  logic              song_done_q, song_done_d;

  logic            tc;
  logic [ADDR_W:0] addr_inc;
  mode_e           mode_sel;

  assign tc = ((state_q == S_INS_BUSY)  && (cnt_q == INS_LAST)) ||
              ((state_q == S_PLAY_NOTE) && (cnt_q == NOTE_LAST));
  assign addr_inc = {1'b0, note_addr_q} + (ADDR_W+1)'(1);

  always_comb begin
    state_d      = state_q;
    note_addr_d  = note_addr_q;
    note_count_d = note_count_q;
    note_code_d  = note_code_q;
    record_en_d  = 1'b0;
    erase_en_d   = 1'b0;
    song_done_d  = 1'b0;
    cnt_d        = '0;

    unique case (state_q)
      S_MENU: begin
        if (make_valid) begin
          case (make_code)
            KEY_INSERT: state_d = S_INS_IDLE;
            KEY_DELETE: begin
              state_d = S_DEL_STEP;
              if (note_count_q != '0) begin
                note_addr_d  = note_count_q[ADDR_W-1:0] - ADDR_W'(1);
                note_count_d = note_count_q - (ADDR_W+1)'(1);
                erase_en_d   = 1'b1;
              end
            end
            KEY_PLAY: begin
              if (note_count_q != '0) begin
                state_d     = S_PLAY_NOTE;
                note_addr_d = '0;
              end
            end
            KEY_ESC: state_d = S_END;
            default: ;
          endcase
        end
      end

      S_INS_IDLE: begin
        if (make_valid) begin
          if (make_code == KEY_ESC) begin
            state_d = S_MENU;
          end else if (note_count_q < MAX_COUNT) begin
            note_code_d  = make_code;
            note_addr_d  = note_count_q[ADDR_W-1:0];
            note_count_d = note_count_q + (ADDR_W+1)'(1);
            record_en_d  = 1'b1;
            state_d      = S_INS_BUSY;
          end
        end
      end

      S_INS_BUSY: begin
        if (tc) begin
          state_d = S_INS_IDLE;
        end
      end

      S_DEL_STEP: state_d = S_MENU;

      S_PLAY_NOTE: begin
        // A key landing on the terminal-count cycle is dropped, Esc included.
        if (tc) begin
          note_addr_d = note_addr_q + ADDR_W'(1);
          if (addr_inc == note_count_q) begin
`ifdef COMPOSER_LOOP_PLAY_EN
            note_addr_d = '0;
            song_done_d = 1'b1;
`else
            state_d     = S_PLAY_END;
            song_done_d = 1'b1;
`endif
          end
        end else if (make_valid && make_code == KEY_ESC) begin
          state_d = S_MENU;
        end
      end

      S_PLAY_END: state_d = S_MENU;

      S_END: ;

      default: state_d = S_MENU;
    endcase

    // Counter restarts on every state entry and after each note.
    if (state_d == state_q && (state_q == S_INS_BUSY || state_q == S_PLAY_NOTE) && !tc) begin
      cnt_d = cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_MENU;
      cnt_q        <= '0;
      note_addr_q  <= '0;
      note_count_q <= '0;
      note_code_q  <= '0;
      record_en_q  <= 1'b0;
      erase_en_q   <= 1'b0;
      song_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      note_addr_q  <= note_addr_d;
      note_count_q <= note_count_d;
      note_code_q  <= note_code_d;
      record_en_q  <= record_en_d;
      erase_en_q   <= erase_en_d;
      song_done_q  <= song_done_d;
    end
  end

  always_comb begin
    mode_sel = MODE_MENU;
    unique case (state_q)
      S_INS_IDLE, S_INS_BUSY:  mode_sel = MODE_INSERT;
      S_DEL_STEP:              mode_sel = MODE_DELETE;
      S_PLAY_NOTE, S_PLAY_END: mode_sel = MODE_PLAY;
      S_END:                   mode_sel = MODE_END;
      default:                 mode_sel = MODE_MENU;
    endcase
  end

  assign mode       = mode_sel;
  assign busy       = (state_q == S_INS_BUSY) || (state_q == S_PLAY_NOTE);
  assign play_en    = (state_q == S_PLAY_NOTE);
  assign record_en  = record_en_q;
  assign erase_en   = erase_en_q;
  assign song_done  = song_done_q;
  assign note_code  = note_code_q;
  assign note_addr  = note_addr_q;
  assign note_count = note_count_q;

endmodule

// File: tb/tb_composer_ctrl.sv
// Directed bench for composer_ctrl with small capacity and short delays.
module tb_composer_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic [2:0] mode;
  logic       record_en, erase_en, play_en, busy, song_done;
  logic [7:0] note_code;
  logic [1:0] note_addr;
  logic [2:0] note_count;

  int checks = 0;
  int errors = 0;

  composer_ctrl #(
    .MAX_NOTES(4), .ADDR_W(2), .INSERT_TICKS(4), .NOTE_TICKS(3), .TICK_W(4)
  ) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .mode(mode), .record_en(record_en), .erase_en(erase_en), .play_en(play_en),
    .note_code(note_code), .note_addr(note_addr), .note_count(note_count),
    .busy(busy), .song_done(song_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] key;
    logic       settle;
    logic [2:0] mode;
    logic [2:0] count;
    logic       rec;
    logic       era;
    logic       busy;
    logic [1:0] addr;
    logic [7:0] code;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_key(input logic [7:0] code);
    @(negedge clock);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clock);
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mode"},  {29'd0, mode}, 32'd0);
    check({tag, "_count"}, {29'd0, note_count}, 32'd0);
    check({tag, "_addr"},  {30'd0, note_addr}, 32'd0);
    check({tag, "_code"},  {24'd0, note_code}, 32'd0);
    check({tag, "_strb"},  {28'd0, record_en, erase_en, play_en, song_done}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nb, rc, n, dones, n_log;
    logic [1:0] log_a[16];

    //           key    st  mode  cnt  rec era bsy addr code
    vecs[0]  = '{8'hF0, 1, 3'd1, 3'd1, 0, 0, 0, 2'd0, 8'h1C};
    vecs[1]  = '{8'h1C, 1, 3'd1, 3'd1, 0, 0, 0, 2'd0, 8'h1C};
    vecs[2]  = '{8'hF0, 1, 3'd1, 3'd1, 0, 0, 0, 2'd0, 8'h1C};
    vecs[3]  = '{8'hE0, 1, 3'd1, 3'd1, 0, 0, 0, 2'd0, 8'h1C};
    vecs[4]  = '{8'h1C, 1, 3'd1, 3'd1, 0, 0, 0, 2'd0, 8'h1C};
    vecs[5]  = '{8'h1B, 0, 3'd1, 3'd2, 1, 0, 1, 2'd1, 8'h1B};
    vecs[6]  = '{8'h33, 1, 3'd1, 3'd2, 0, 0, 1, 2'd1, 8'h1B};
    vecs[7]  = '{8'h23, 1, 3'd1, 3'd3, 1, 0, 1, 2'd2, 8'h23};
    vecs[8]  = '{8'h2B, 1, 3'd1, 3'd4, 1, 0, 1, 2'd3, 8'h2B};
    vecs[9]  = '{8'h34, 1, 3'd1, 3'd4, 0, 0, 0, 2'd3, 8'h2B};
    vecs[10] = '{8'h76, 1, 3'd0, 3'd4, 0, 0, 0, 2'd3, 8'h2B};
    vecs[11] = '{8'h1E, 1, 3'd2, 3'd3, 0, 1, 0, 2'd3, 8'h2B};
    vecs[12] = '{8'h1E, 1, 3'd2, 3'd2, 0, 1, 0, 2'd2, 8'h2B};
    vecs[13] = '{8'h1E, 1, 3'd2, 3'd1, 0, 1, 0, 2'd1, 8'h2B};
    vecs[14] = '{8'h1E, 1, 3'd2, 3'd0, 0, 1, 0, 2'd0, 8'h2B};
    vecs[15] = '{8'h1E, 1, 3'd2, 3'd0, 0, 0, 0, 2'd0, 8'h2B};
    vecs[16] = '{8'h26, 1, 3'd0, 3'd0, 0, 0, 0, 2'd0, 8'h2B};

    do_reset();
    @(negedge clock);
    check_reset_values("reset");

    // Insert basic: record strobe, pointer update, 4-cycle busy window
    send_key(8'h16);
    check("ins_mode", {29'd0, mode}, 32'd1);
    send_key(8'h1C);
    check("ins_code",  {24'd0, note_code}, 32'h1C);
    check("ins_addr",  {30'd0, note_addr}, 32'd0);
    check("ins_count", {29'd0, note_count}, 32'd1);
    nb = 0;
    rc = 0;
    for (int c = 0; c < 12; c++) begin
      if (busy) nb++;
      if (record_en) rc++;
      @(negedge clock);
    end
    check("ins_busy_cycles", nb, 32'd4);
    check("ins_record_pulses", rc, 32'd1);
    check("ins_mode_after", {29'd0, mode}, 32'd1);

    // Table: break filter, busy drop, full, deletes, empty play
    for (int i = 0; i < 17; i++) begin
      send_key(vecs[i].key);
      check($sformatf("vec%0d_mode", i),  {29'd0, mode}, {29'd0, vecs[i].mode});
      check($sformatf("vec%0d_count", i), {29'd0, note_count}, {29'd0, vecs[i].count});
      check($sformatf("vec%0d_rec", i),   {31'd0, record_en}, {31'd0, vecs[i].rec});
      check($sformatf("vec%0d_era", i),   {31'd0, erase_en}, {31'd0, vecs[i].era});
      check($sformatf("vec%0d_busy", i),  {31'd0, busy}, {31'd0, vecs[i].busy});
      check($sformatf("vec%0d_addr", i),  {30'd0, note_addr}, {30'd0, vecs[i].addr});
      check($sformatf("vec%0d_code", i),  {24'd0, note_code}, {24'd0, vecs[i].code});
      if (vecs[i].settle) wait_idle();
    end

    // Three notes for playback
    send_key(8'h16);
    send_key(8'h15); wait_idle();
    send_key(8'h1D); wait_idle();
    send_key(8'h24); wait_idle();
    send_key(8'h76);
    check("pre_play_count", {29'd0, note_count}, 32'd3);

`ifndef COMPOSER_LOOP_PLAY_EN
    send_key(8'h26);
    check("play_mode", {29'd0, mode}, 32'd3);
    n_log = 0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (play_en) begin
        if (n_log < 16) log_a[n_log] = note_addr;
        n_log++;
      end
      if (song_done) begin
        dones++;
        check("done_play_low", {31'd0, play_en}, 32'd0);
      end
      @(negedge clock);
    end
    check("play_cycles", n_log, 32'd9);
    for (int i = 0; i < 9; i++)
      check($sformatf("play_addr%0d", i), {30'd0, log_a[i]}, i / 3);
    check("play_done_pulses", dones, 32'd1);
    check("play_mode_after", {29'd0, mode}, 32'd0);
`endif

    // Abort during the second note
    send_key(8'h26);
    n = 0;
    while (note_addr != 2'd1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("abort_reach_addr1", {30'd0, note_addr}, 32'd1);
    send_key(8'h76);
    check("abort_play_en", {31'd0, play_en}, 32'd0);
    check("abort_mode", {29'd0, mode}, 32'd0);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (song_done) dones++;
      @(negedge clock);
    end
    check("abort_no_done", dones, 32'd0);

`ifdef COMPOSER_LOOP_PLAY_EN
    do_reset();
    send_key(8'h16);
    send_key(8'h15); wait_idle();
    send_key(8'h1D); wait_idle();
    send_key(8'h76);
    send_key(8'h26);
    for (int c = 0; c < 12; c++) begin
      check($sformatf("loop_play_en%0d", c), {31'd0, play_en}, 32'd1);
      check($sformatf("loop_addr%0d", c), {30'd0, note_addr}, (c / 3) % 2);
      check($sformatf("loop_done%0d", c), {31'd0, song_done}, (c == 6) ? 32'd1 : 32'd0);
      @(negedge clock);
    end
    send_key(8'h76);
    check("loop_esc_mode", {29'd0, mode}, 32'd0);
`endif

    // Reset while the insert hold-off is running
    send_key(8'h16);
    send_key(8'h2C);
    check("rst_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("rst_mid");
    reset = 1'b0;

    // END is absorbing
    send_key(8'h76);
    check("end_mode", {29'd0, mode}, 32'd4);
    send_key(8'h16);
    check("end_ins_ignored", {29'd0, mode}, 32'd4);
    send_key(8'h76);
    check("end_esc_ignored", {29'd0, mode}, 32'd4);
    send_key(8'h26);
    check("end_play_ignored", {29'd0, mode}, 32'd4);
    check("end_play_en", {31'd0, play_en}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/composer_ctrl.md
Name: composer_ctrl

Overview:
- Sequencing controller for the composer datapath.
- Decodes PS/2 key events into mode changes: menu, insert, delete, play, end.
- Owns the song write pointer and note count.
- Issues record, erase and play strobes to the piano/note engine, with timing from internal delay counters.
- Drives the mode code that selects which VGA screen the display mux shows.

Parameters:
- MAX_NOTES, 32, capacity of the song store in notes.
- ADDR_W, 5, note address width; 2**ADDR_W >= MAX_NOTES.
- INSERT_TICKS, 5000000, clock cycles to hold busy after a note insert (100 ms at 50 MHz).
- NOTE_TICKS, 25000000, clock cycles each note sounds during playback.
- TICK_W, 25, width of the shared delay counter; must hold max(INSERT_TICKS, NOTE_TICKS).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- key_valid  in  1  one-cycle strobe; key_code is valid.
- key_code  in  8  PS/2 set-2 scancode byte.
- mode  out  3  0 MENU, 1 INSERT, 2 DELETE, 3 PLAY, 4 END; drives VGA screen select.
- record_en  out  1  one-cycle strobe: write note_code at note_addr.
- erase_en  out  1  one-cycle strobe: clear the note at note_addr.
- play_en  out  1  level: sound the note at note_addr.
- note_code  out  8  scancode of the note being recorded.
- note_addr  out  ADDR_W  current note address.
- note_count  out  ADDR_W+1  number of stored notes.
- busy  out  1  high while a delay counter runs; key events are ignored.
- song_done  out  1  one-cycle strobe when playback finishes.

Behaviour:
- Reset values:
  - State MENU; mode 0.
  - All strobes 0; play_en 0; busy 0.
  - note_count 0; note_addr 0; note_code 0; break flag 0; counter 0.
- Break-code filter:
  - key_code 0xF0 with key_valid sets the break flag.
  - The next valid byte clears the flag and is discarded.
  - Only make codes reach the FSM.
  - 0xE0 prefix bytes are discarded without touching the flag.
- Command keys: 0x16 ('1') insert, 0x1E ('2') delete, 0x26 ('3') play, 0x76 (Esc) back/end.
- MENU:
  - '1' -> INS_IDLE.
  - '2' -> DEL_STEP.
  - '3' -> PLAY_NOTE if note_count > 0, else stay in MENU.
  - Esc -> END.
  - Any other key is ignored.
- INS_IDLE (mode 1):
  - Esc -> MENU.
  - Any other make code when note_count < MAX_NOTES:
    - Same cycle: note_code <= key, note_addr <= note_count.
    - Next cycle: record_en = 1, note_count increments.
    - Enter INS_BUSY.
  - When full, the key is dropped and the state stays INS_IDLE.
- INS_BUSY:
  - busy = 1; the counter runs 0..INSERT_TICKS-1.
  - Terminal count -> INS_IDLE.
  - Key events during busy are dropped.
- DEL_STEP (mode 2):
  - If note_count > 0: note_addr <= note_count-1; erase_en pulses one cycle; note_count decrements.
  - Always returns to MENU the following cycle.
  - Deleting from an empty song is a no-op.
- PLAY_NOTE (mode 3):
  - note_addr starts at 0; play_en = 1; busy = 1.
  - The counter runs to NOTE_TICKS-1.
  - Then note_addr increments; if the new address equals note_count -> PLAY_END.
  - Esc during play is honoured despite busy: play_en drops next cycle -> MENU.
- PLAY_END: song_done pulses for one cycle; play_en = 0 -> MENU.
- END (mode 4): absorbing; only reset leaves it.
- Counter:
  - One TICK_W up-counter shared by INS_BUSY and PLAY_NOTE.
  - Cleared on every state entry.
  - Never wraps within a state.
- key_valid in the same cycle as a counter terminal count: the key is dropped.
- Reset asserted mid-operation (insert, play or end) returns everything to reset values next edge.
- Song contents are external and are not cleared by this block.

Optional Feature:
- Macro: COMPOSER_LOOP_PLAY_EN.
- Defined:
  - At the end of the song, note_addr wraps to 0 and playback continues.
  - song_done pulses at each wrap.
  - Only Esc or reset exits PLAY.
- Undefined: single pass, as described above.

Decomposition:
- Package composer_pkg holds:
  - mode enum and FSM state enum;
  - scancode constants KEY_INSERT, KEY_DELETE, KEY_PLAY, KEY_ESC, KEY_BREAK, KEY_EXT.
- One sub-module, ps2_make_filter:
  - contains the break/extended-byte filter;
  - outputs make_valid and make_code.
- The FSM, counter and pointer logic stay in composer_ctrl.

Test Plan:
- Insert basic (INSERT_TICKS=4):
  - Stimulus: reset; keys 0x16, then 0x1C.
  - Response: record_en for exactly 1 cycle; note_code 0x1C, note_addr 0, note_count 1; busy high 4 cycles; mode 1.
- Break filter:
  - Stimulus: in INS_IDLE, bytes 0xF0, 0x1C.
  - Response: no record_en; note_count unchanged.
- Full/empty:
  - Stimulus (MAX_NOTES=4): insert 5 notes.
  - Response: count saturates at 4; the 5th produces no strobe.
  - Stimulus: Esc, then 5 × '2'.
  - Response: 4 erase_en strobes at addresses 3,2,1,0; count 0; the 5th is a no-op.
- Playback (NOTE_TICKS=3, 3 notes):
  - Stimulus: '3'.
  - Response: note_addr 0,1,2, each held 3 cycles with play_en=1; song_done pulses once; mode returns to 0.
- Abort and reset:
  - Stimulus: Esc during the second note of playback.
  - Response: play_en low next cycle; mode 0; no song_done.
  - Stimulus: reset during INS_BUSY.
  - Response: all outputs return to reset values.
- End/loop:
  - Stimulus: Esc in MENU.
  - Response: mode 4, and all keys are ignored afterwards.
  - Stimulus: COMPOSER_LOOP_PLAY_EN defined, 2 notes.
  - Response: address sequence 0,1,0,1 with song_done at each wrap.
